// File: rtl/muldiv_if.sv
// Handshake and HI/LO bus between a requester and muldiv_unit.
// The requester drives operands and mthi/mtlo writes; the unit returns status and HI/LO.
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             dz;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, hi_we, lo_we, wdata,
        input  busy, done, dz, hi, lo
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we, wdata,
        output busy, done, dz, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: one shift-add or restoring
// shift-subtract step per cycle, sign fix-up and commit in FINAL.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input logic      clk,
    input logic      reset,
    muldiv_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FINAL
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] araw_q, araw_d;
    logic             is_div_q, is_div_d;
    logic             neg_lo_q, neg_lo_d;
    logic             neg_hi_q, neg_hi_d;
    logic             divz_q, divz_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;
    logic             dz_q, dz_d;

    logic             sgn;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;

    // Operand magnitudes; only MULT/DIV (op[0]=0) are signed.
    always_comb begin
        sgn   = ~bus.op[0];
        a_neg = sgn & bus.a[WIDTH-1];
        b_neg = sgn & bus.b[WIDTH-1];
        a_mag = a_neg ? -bus.a : bus.a;
        b_mag = b_neg ? -bus.b : bus.b;
    end

    // Datapath for one iteration and for the final sign correction.
    always_comb begin
        sum      = {1'b0, rem_q} + {1'b0, (quo_q[0] ? mcand_q : '0)};
        shifted  = {rem_q, quo_q[WIDTH-1]};
        diff     = shifted - {1'b0, mcand_q};
        prod     = {rem_q, quo_q};
        prod_fix = neg_lo_q ? -prod : prod;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        araw_d   = araw_q;
        is_div_d = is_div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        divz_d   = divz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        dz_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.hi_we) hi_d = bus.wdata;
                if (bus.lo_we) lo_d = bus.wdata;
                if (bus.start) begin
                    state_d  = CALC;
                    cnt_d    = '0;
                    is_div_d = bus.op[1];
                    neg_lo_d = a_neg ^ b_neg;
                    neg_hi_d = a_neg;
                    divz_d   = bus.op[1] & (bus.b == '0);
                    araw_d   = bus.a;
                    rem_d    = '0;
                    if (bus.op[1]) begin
                        quo_d   = a_mag;
                        mcand_d = b_mag;
                    end else begin
                        quo_d   = b_mag;
                        mcand_d = a_mag;
                    end
                end
            end
            CALC: begin
                if (is_div_q) begin
                    // Restoring step: keep the trial difference if no borrow.
                    if (!diff[WIDTH]) begin
                        rem_d = diff[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = shifted[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    rem_d = sum[WIDTH:1];
                    quo_d = {sum[0], quo_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) state_d = FINAL;
            end
            FINAL: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (is_div_q) begin
                    if (divz_q) begin
                        lo_d = '1;
                        hi_d = araw_q;
                        dz_d = 1'b1;
                    end else begin
                        lo_d = neg_lo_q ? -quo_q : quo_q;
                        hi_d = neg_hi_q ? -rem_q : rem_q;
                    end
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            araw_q   <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            divz_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            araw_q   <= araw_d;
            is_div_q <= is_div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            divz_q   <= divz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            dz_q     <= dz_d;
        end
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = done_q;
    assign bus.dz   = dz_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits; legal range 4..64.
REQ-002 SHALL have port clk, input, 1, clock; all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1, request a new operation; sampled on rising clk.
REQ-005 SHALL have port op, input, 2, operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have ports a and b, input, WIDTH each, operands; a is dividend, b is divisor.
REQ-007 SHALL have ports hi_we and lo_we, input, 1 each, direct writes to HI/LO (mthi/mtlo).
REQ-008 SHALL have port wdata, input, WIDTH, data for hi_we/lo_we.
REQ-009 SHALL have port busy, output, 1, operation in progress.
REQ-010 SHALL have port done, output, 1, one-cycle pulse when a result is committed.
REQ-011 SHALL have port dz, output, 1, divide-by-zero flag; valid while done=1, else 0.
REQ-012 SHALL have ports hi and lo, output, WIDTH each, HI/LO registers, readable at all times.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, FINAL; busy=1 in CALC and FINAL only.
REQ-014 SHALL, in IDLE with start=1 at edge k: latch operands as magnitudes (signed ops) and record sign of result/remainder, then enter CALC.
REQ-015 SHALL perform one shift-add (multiply) or one restoring shift-subtract (divide) step per cycle, WIDTH steps, at edges k+1..k+WIDTH, using a step counter of ceil(log2(WIDTH+1)) bits.
REQ-016 SHALL, at edge k+WIDTH+1 (FINAL), apply two's-complement sign correction, write hi/lo, return to IDLE, and drive done=1 for exactly the following cycle.
REQ-017 SHALL for multiply write the 2*WIDTH-bit product, upper half to hi, lower half to lo.
REQ-018 SHALL for divide write quotient to lo and remainder to hi; signed quotient truncates toward zero; remainder sign equals dividend sign.
REQ-019 SHALL for DIV with a = most-negative and b = -1 produce lo = most-negative value, hi = 0, dz=0.
REQ-020 SHALL for divide with b=0 still take WIDTH+1 cycles, then write lo = all ones, hi = a unmodified, dz=1 with done.
REQ-021 SHALL ignore start while busy=1; operands and op of the running operation are unaffected.
REQ-022 SHALL accept start in the same cycle done=1 (busy=0), giving back-to-back throughput of WIDTH+1 cycles.
REQ-023 SHALL perform hi_we/lo_we writes only when busy=0; ignored while busy=1.
REQ-024 SHALL, when hi_we/lo_we and start coincide in IDLE, perform the write at that edge and also accept start; the operation result later overwrites both.
REQ-025 SHALL not change hi/lo except via REQ-016 commit, REQ-023 writes, or reset.

Reset
REQ-026 SHALL on reset asynchronously force state IDLE, busy=0, done=0, dz=0, hi=0, lo=0, step counter=0.
REQ-027 SHALL on reset mid-operation discard the operation without committing any partial result; first edge after reset release may accept start.

Verification (WIDTH=32)
REQ-028 SHALL verify MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> after 33 cycles hi=0xFFFFFFFE, lo=0x00000001, done one cycle, busy 0.
REQ-029 SHALL verify MULT a=-3 b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; then DIVU 100/7 started same cycle as done -> lo=14, hi=2.
REQ-030 SHALL verify DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
REQ-031 SHALL verify DIV 5/0 -> lo=0xFFFFFFFF, hi=5, dz=1 with done, dz=0 next cycle.
REQ-032 SHALL verify start and hi_we pulsed mid-operation ignored (result = original operands, hi not wdata); hi_we with wdata=0x1234 in IDLE -> hi=0x1234, lo unchanged.
REQ-033 SHALL verify reset asserted at step 10 of MULTU -> busy=0, hi=lo=0 immediately, no done pulse; new start after release completes correctly.
